// File: rtl/ex_alu_stage_pkg.sv
// Shared ALUop encodings and width for the EX-stage ALU and any future consumers of alu_core.
// Codes not listed here, including ALU_XXX, are treated as illegal by the datapath.
package ex_alu_stage_pkg;

   localparam int ALU_W = 4;

   localparam logic [ALU_W-1:0] ALU_ADDU = 4'd0;
   localparam logic [ALU_W-1:0] ALU_SUBU = 4'd1;
   localparam logic [ALU_W-1:0] ALU_AND  = 4'd2;
   localparam logic [ALU_W-1:0] ALU_OR   = 4'd3;
   localparam logic [ALU_W-1:0] ALU_XOR  = 4'd4;
   localparam logic [ALU_W-1:0] ALU_NOR  = 4'd5;
   localparam logic [ALU_W-1:0] ALU_SLT  = 4'd6;
   localparam logic [ALU_W-1:0] ALU_SLTU = 4'd7;
   localparam logic [ALU_W-1:0] ALU_SLL  = 4'd8;
   localparam logic [ALU_W-1:0] ALU_SRL  = 4'd9;
   localparam logic [ALU_W-1:0] ALU_SRA  = 4'd10;
   localparam logic [ALU_W-1:0] ALU_LUI  = 4'd11;
   localparam logic [ALU_W-1:0] ALU_BEQ  = 4'd12;
   localparam logic [ALU_W-1:0] ALU_BNE  = 4'd13;
   localparam logic [ALU_W-1:0] ALU_XXX  = 4'd15;

   function automatic logic is_branch_op(input logic [ALU_W-1:0] op);
      return (op == ALU_BEQ) || (op == ALU_BNE);
   endfunction

endpackage

// File: rtl/ex_alu_stage_alu_core.sv
// Purely combinational ALU: result, branch resolution and illegal-op flag from alu_op, a, b.
// Zero latency, no flow control; shared by the EX stage and any later compare/forwarding unit.
module alu_core
   import ex_alu_stage_pkg::*;
#(
   parameter int DW = 32
)
(
   input  logic [ALU_W-1:0] alu_op,
   input  logic [DW-1:0]    a,
   input  logic [DW-1:0]    b,
   output logic [DW-1:0]    result,
   output logic             br_taken,
   output logic             is_branch,
   output logic             illegal
);

   logic [4:0] shamt;
   assign shamt = a[4:0];

   always_comb begin
      result    = '0;
      br_taken  = 1'b0;
      is_branch = is_branch_op(alu_op);
      illegal   = 1'b0;
      case (alu_op)
         ALU_ADDU: result = a + b;
         ALU_SUBU: result = a - b;
         ALU_AND:  result = a & b;
         ALU_OR:   result = a | b;
         ALU_XOR:  result = a ^ b;
         ALU_NOR:  result = ~(a | b);
         ALU_SLT:  result = {{(DW-1){1'b0}}, ($signed(a) < $signed(b))};
         ALU_SLTU: result = {{(DW-1){1'b0}}, (a < b)};
         ALU_SLL:  result = b << shamt;
         ALU_SRL:  result = b >> shamt;
         ALU_SRA:  result = $signed(b) >>> shamt;
         ALU_LUI:  result = b << 16;
         ALU_BEQ: begin
            result   = a - b;
            br_taken = (a == b);
         end
         ALU_BNE: begin
            result   = a - b;
            br_taken = (a != b);
         end
         // ALU_XXX and unassigned codes still flow so MEM/WB can raise the exception
         default:  illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/ex_alu_stage.sv
// EX-stage ALU plus single-entry EX/MEM register; 1-cycle latency, full throughput.
// in_ready = !out_valid || out_ready, so a MEM stall holds all outputs and back-pressures ID/EX.
module ex_alu_stage
   import ex_alu_stage_pkg::*;
#(
   parameter int DW   = 32,
   parameter int SB_W = 8
)
(
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [ALU_W-1:0] alu_op,
   input  logic [DW-1:0]    a,
   input  logic [DW-1:0]    b,
   input  logic [SB_W-1:0]  sb_in,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [DW-1:0]    result,
   output logic [SB_W-1:0]  sb_out,
   output logic             br_valid,
   output logic             br_taken,
   output logic             illegal
);

   logic [DW-1:0] alu_result;
   logic          alu_br_taken;
   logic          alu_is_branch;
   logic          alu_illegal;
   logic          capture;

   alu_core #(.DW(DW)) u_alu_core (
      .alu_op    (alu_op),
      .a         (a),
      .b         (b),
      .result    (alu_result),
      .br_taken  (alu_br_taken),
      .is_branch (alu_is_branch),
      .illegal   (alu_illegal)
   );

   assign in_ready = !out_valid || out_ready;
   assign capture  = in_valid && in_ready && !flush;

   // flush beats capture and drain; result/sb_out are left stale when out_valid drops
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_valid <= 1'b0;
         result    <= '0;
         sb_out    <= '0;
         br_valid  <= 1'b0;
         br_taken  <= 1'b0;
         illegal   <= 1'b0;
      end else if (flush) begin
         out_valid <= 1'b0;
         br_valid  <= 1'b0;
         br_taken  <= 1'b0;
         illegal   <= 1'b0;
      end else if (capture) begin
         out_valid <= 1'b1;
         result    <= alu_result;
         sb_out    <= sb_in;
         br_valid  <= alu_is_branch;
         br_taken  <= alu_br_taken;
         illegal   <= alu_illegal;
      end else if (out_ready) begin
         out_valid <= 1'b0;
         br_valid  <= 1'b0;
         br_taken  <= 1'b0;
         illegal   <= 1'b0;
      end
   end

endmodule

// File: tb/tb_ex_alu_stage.sv
// Scoreboard bench for ex_alu_stage: directed vectors push hand-computed expectations,
// a negedge monitor pops and compares on every output handshake.
module tb_ex_alu_stage;
   import ex_alu_stage_pkg::*;

   localparam int DW   = 32;
   localparam int SB_W = 8;

   typedef struct {
      logic [31:0] res;
      logic [7:0]  sb;
      logic        brv;
      logic        brt;
      logic        ill;
   } exp_t;

   logic             clk;
   logic             reset;
   logic             in_valid;
   logic             in_ready;
   logic [ALU_W-1:0] alu_op;
   logic [DW-1:0]    a;
   logic [DW-1:0]    b;
   logic [SB_W-1:0]  sb_in;
   logic             flush;
   logic             out_valid;
   logic             out_ready;
   logic [DW-1:0]    result;
   logic [SB_W-1:0]  sb_out;
   logic             br_valid;
   logic             br_taken;
   logic             illegal;

   int   checks = 0;
   int   errors = 0;
   exp_t sb_q[$];
   exp_t mon_e;

   ex_alu_stage #(.DW(DW), .SB_W(SB_W)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .alu_op    (alu_op),
      .a         (a),
      .b         (b),
      .sb_in     (sb_in),
      .flush     (flush),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .sb_out    (sb_out),
      .br_valid  (br_valid),
      .br_taken  (br_taken),
      .illegal   (illegal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // Monitor: a transfer happens at the next posedge when out_valid && out_ready && !flush
   always @(negedge clk) begin
      if (!reset && out_valid && out_ready && !flush) begin
         if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output: got result 0x%08h, expected no output", result);
         end else begin
            mon_e = sb_q.pop_front();
            chk("result",   result,   mon_e.res);
            chk("sb_out",   {24'h0, sb_out}, {24'h0, mon_e.sb});
            chk("br_valid", {31'h0, br_valid}, {31'h0, mon_e.brv});
            chk("br_taken", {31'h0, br_taken}, {31'h0, mon_e.brt});
            chk("illegal",  {31'h0, illegal},  {31'h0, mon_e.ill});
         end
      end
   end

   task automatic send(input logic [3:0] op, input logic [31:0] av, input logic [31:0] bv,
                       input logic [7:0] sbv, input logic [31:0] er,
                       input logic ebv, input logic ebt, input logic eil);
      int   n;
      logic rdy;
      exp_t e;
      alu_op   = op;
      a        = av;
      b        = bv;
      sb_in    = sbv;
      in_valid = 1'b1;
      n        = 0;
      do begin
         @(negedge clk);
         rdy = in_ready;
         @(posedge clk);
         n++;
      end while (!rdy && n < 50);
      if (!rdy) begin
         checks++;
         errors++;
         $display("FAIL send_timeout: got in_ready=0 for %0d cycles, expected 1", n);
      end else begin
         e.res = er; e.sb = sbv; e.brv = ebv; e.brt = ebt; e.ill = eil;
         sb_q.push_back(e);
      end
      #1;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb_q.size() != 0 && n < 20) begin
         @(posedge clk);
         n++;
      end
      #1;
      chk("drain_pending", sb_q.size(), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish after 200000 time units, expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset = 1'b1; in_valid = 1'b0; alu_op = '0; a = '0; b = '0;
      sb_in = '0; flush = 1'b0; out_ready = 1'b0;
      #2;
      chk("rst_out_valid", {31'h0, out_valid}, 0);
      chk("rst_result",    result, 0);
      chk("rst_sb_out",    {24'h0, sb_out}, 0);
      chk("rst_br_valid",  {31'h0, br_valid}, 0);
      chk("rst_br_taken",  {31'h0, br_taken}, 0);
      chk("rst_illegal",   {31'h0, illegal}, 0);
      @(posedge clk); @(posedge clk); #1;
      reset = 1'b0;
      #1;
      chk("rst_in_ready", {31'h0, in_ready}, 1);
      out_ready = 1'b1;

      // Functional vectors, streamed back to back
      send(ALU_ADDU, 32'hFFFF_FFFF, 32'h1,          8'h01, 32'h0000_0000, 0, 0, 0);
      send(ALU_SLT,  32'hFFFF_FFFF, 32'h1,          8'h02, 32'h0000_0001, 0, 0, 0);
      send(ALU_SLTU, 32'hFFFF_FFFF, 32'h1,          8'h03, 32'h0000_0000, 0, 0, 0);
      send(ALU_SRA,  32'h4,         32'h8000_0000,  8'h04, 32'hF800_0000, 0, 0, 0);
      send(ALU_SRL,  32'h4,         32'h8000_0000,  8'h05, 32'h0800_0000, 0, 0, 0);
      send(ALU_SLL,  32'h8,         32'h1,          8'h06, 32'h0000_0100, 0, 0, 0);
      send(ALU_LUI,  32'h0,         32'h1234_ABCD,  8'h07, 32'hABCD_0000, 0, 0, 0);
      send(ALU_SUBU, 32'h3,         32'h5,          8'h08, 32'hFFFF_FFFE, 0, 0, 0);
      send(ALU_AND,  32'hFF00_FF00, 32'h0FF0_0FF0,  8'h09, 32'h0F00_0F00, 0, 0, 0);
      send(ALU_OR,   32'hFF00_FF00, 32'h0FF0_0FF0,  8'h0A, 32'hFFF0_FFF0, 0, 0, 0);
      send(ALU_XOR,  32'hFF00_FF00, 32'h0FF0_0FF0,  8'h0B, 32'hF0F0_F0F0, 0, 0, 0);
      send(ALU_NOR,  32'h0,         32'hF0F0_F0F0,  8'h0C, 32'h0F0F_0F0F, 0, 0, 0);
      send(ALU_BEQ,  32'h1234,      32'h1234,       8'h0D, 32'h0000_0000, 1, 1, 0);
      send(ALU_BNE,  32'h1234,      32'h1234,       8'h0E, 32'h0000_0000, 1, 0, 0);
      send(ALU_BNE,  32'h5,         32'h3,          8'h0F, 32'h0000_0002, 1, 1, 0);
      send(4'd14,    32'h1,         32'h2,          8'h10, 32'h0000_0000, 0, 0, 1);
      drain();

      // Back-pressure: ADDU 2+3 held for 3 cycles while SUBU 9-2 waits
      out_ready = 1'b0;
      send(ALU_ADDU, 32'h2, 32'h3, 8'h25, 32'h5, 0, 0, 0);
      alu_op = ALU_SUBU; a = 32'h9; b = 32'h2; sb_in = 8'h26; in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("stall_in_ready",  {31'h0, in_ready}, 0);
         chk("stall_out_valid", {31'h0, out_valid}, 1);
         chk("stall_result",    result, 32'h5);
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      @(posedge clk);
      mon_e.res = 32'h7; mon_e.sb = 8'h26; mon_e.brv = 0; mon_e.brt = 0; mon_e.ill = 0;
      sb_q.push_back(mon_e);
      #1;
      in_valid = 1'b0;
      drain();

      // Flush kills the held BEQ and the op offered on the same edge
      out_ready = 1'b0;
      send(ALU_BEQ, 32'h7, 32'h7, 8'h30, 32'h0, 1, 1, 0);
      alu_op = ALU_AND; a = 32'hFFFF_FFFF; b = 32'h1; sb_in = 8'h31;
      in_valid = 1'b1; flush = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      chk("preflush_br_valid", {31'h0, br_valid}, 1);
      @(posedge clk); #1;
      flush = 1'b0; in_valid = 1'b0;
      sb_q.delete();
      @(negedge clk);
      chk("flush_out_valid", {31'h0, out_valid}, 0);
      chk("flush_br_valid",  {31'h0, br_valid}, 0);
      chk("flush_illegal",   {31'h0, illegal}, 0);
      @(negedge clk);
      chk("flush_dropped", {31'h0, out_valid}, 0);

      // Asynchronous reset between edges with a held entry
      @(posedge clk); #1;
      out_ready = 1'b0;
      send(ALU_ADDU, 32'h7, 32'h1, 8'h50, 32'h8, 0, 0, 0);
      #2;
      reset = 1'b1;
      #1;
      chk("arst_out_valid", {31'h0, out_valid}, 0);
      chk("arst_result",    result, 0);
      chk("arst_sb_out",    {24'h0, sb_out}, 0);
      sb_q.delete();
      @(posedge clk); #1;
      reset = 1'b0;
      out_ready = 1'b1;
      send(ALU_XXX, 32'h3, 32'h4, 8'h60, 32'h0, 0, 0, 1);
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ex_alu_stage.md
Name: ex_alu_stage

Overview:
EX-stage execute unit plus EX/MEM pipeline register.
- Consumes the 4-bit ALUop from the ALU decoder, together with the two operands and sideband control from ID/EX.
- Computes the result, resolves BEQ/BNE, and holds everything in a single-entry output register.
- Uses a valid/ready handshake on both sides, so MEM-stage stalls back-pressure cleanly into EX.

Parameters:
- DW, 32: operand and result width.
- SB_W, 8: width of the sideband bus passed through unmodified (dest reg, wb_en, mem ctrl).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  upstream holds a valid op.
- in_ready  out  1  stage can accept this cycle.
- alu_op  in  4  ALUop code (ALU_* encodings).
- a  in  DW  operand A (rs, or shamt zero-extended for SLL/SRL/SRA).
- b  in  DW  operand B (rt, or extended immediate).
- sb_in  in  SB_W  sideband in.
- flush  in  1  kill the held entry and any entry offered this cycle.
- out_valid  out  1  output register holds a valid result.
- out_ready  in  1  downstream accepts.
- result  out  DW  registered ALU result.
- sb_out  out  SB_W  registered sideband.
- br_valid  out  1  held entry is BEQ/BNE.
- br_taken  out  1  branch condition true.
- illegal  out  1  held entry carried ALU_XXX or an unknown code.

Behaviour:
Reset:
- Asynchronous on reset high.
- out_valid=0, result=0, sb_out=0, br_valid=0, br_taken=0, illegal=0.
- in_ready reads 1 once reset deasserts.

Handshake:
- in_ready = !out_valid || out_ready (combinational; bubble-collapsing, full throughput).
- Capture when in_valid && in_ready && !flush. Latency is 1 cycle: an op captured at edge N is visible on the outputs after edge N.
- out_valid clears on an edge where out_ready=1 and nothing is captured.
- Simultaneous drain and capture is allowed: the new entry replaces the old with no bubble.
- While out_valid && !out_ready, all outputs hold stable and in_ready=0.

Flush:
- On any edge with flush=1: out_valid<=0, br_valid<=0, illegal<=0, and no capture.
- result and sb_out may retain stale data; they are don't-care while out_valid=0.
- Flush has priority over capture and over drain.

ALU ops (all unsigned modulo 2^DW, no overflow trap):
- ADDU a+b; SUBU a-b.
- AND, OR, XOR, NOR: bitwise.
- SLT: signed a<b, giving {0..,1} or 0. SLTU: unsigned a<b.
- SLL/SRL/SRA: shift b by a[4:0]; SRA sign-fills from b[DW-1].
- LUI: {b[15:0],16'b0}.
- BEQ/BNE:
  - result = a-b.
  - br_valid=1.
  - BEQ: br_taken = (a==b).
  - BNE: br_taken = (a!=b).
- br_valid=0 and br_taken=0 for every non-branch op.
- ALU_XXX or an undefined code: result=0, illegal=1, entry still flows so it can raise an exception downstream.

Structure:
- No other state and no multi-cycle ops.
- Datapath is purely combinational into the register.

Decomposition:
- ALU_* 4-bit codes stay in the shared ALUop.vh header; this block includes it and defines no codes locally.
- Add ALU_W=4 to that header.
- One natural sub-module: alu_core, purely combinational (alu_op, a, b -> result, br_taken, is_branch, illegal).
  - ex_alu_stage wraps alu_core with the handshake/register logic.
  - alu_core is reusable by a future forwarding or compare unit.

Test Plan:
- ADDU a=0xFFFFFFFF, b=1, in_valid=1, out_ready=1 -> next cycle out_valid=1, result=0x00000000, br_valid=0.
- SLT a=0xFFFFFFFF, b=1 -> result=1. SLTU with the same operands -> result=0. SRA b=0x80000000, a=4 -> result=0xF8000000.
- BEQ a=b=0x1234 -> br_valid=1, br_taken=1. BNE with the same operands -> br_taken=0. Back-to-back, no bubble.
- Back-pressure: capture ADDU 2+3, hold out_ready=0 for 3 cycles:
  - result=5 stable and in_ready=0 throughout.
  - A new op offered meanwhile is not captured until out_ready=1, then appears one cycle later.
- flush=1 while out_valid=1 and a new op is offered -> next cycle out_valid=0, the offered op is dropped, br_valid=0.
- Assert reset mid-stream, asynchronously between edges, with out_valid=1 -> outputs clear immediately without a clock. After release, alu_op=ALU_XXX -> result=0, illegal=1.
